dmem_ctrl: RTL and testbench

Parametrised, handshaked data memory for the MIPS datapath that replaces the single-cycle word/half/byte store memory.
- Accepts one load or store per request. Sizes: byte, half, word.
- Loads are sign- or zero-extended.
- A configurable number of wait states models slower memory for the multicycle/pipelined core.
- Out-of-range accesses and reserved sizes are reported instead of silently corrupting memory.

---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle for the handshaked data memory.
// The master drives the request, and the slave (dmem_ctrl) drives ready and the response.
interface dmem_ctrl_if;
   logic        req;
   logic        ready;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, size, uns, addr, wdata,
      input  ready, done, rdata, err
   );

   modport slave (
      input  req, we, size, uns, addr, wdata,
      output ready, done, rdata, err
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Handshaked byte/half/word data memory with configurable wait states and error reporting.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module dmem_ctrl #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   dmem_ctrl_if.slave  bus
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      r_state, w_state_next;
   logic [3:0]  r_cnt;
   logic        r_we, r_uns;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_wdata;
   logic        r_done, r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_mem [DEPTH];

   logic        w_accept, w_commit;
   logic        w_we, w_uns, w_err, w_oob, w_mis;
   logic [1:0]  w_size;
   logic [31:0] w_addr, w_wdata;
   logic [AW-1:0] w_idx;
   logic [4:0]  w_bsh, w_hsh;
   logic [31:0] w_old, w_mask, w_wdat, w_new, w_load;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.req) begin
               w_accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_state_next = StResp;
                  w_commit     = 1'b1;
               end else begin
                  w_state_next = StWait;
               end
            end
         end
         StWait: begin
            if (r_cnt == 4'd0) begin
               w_state_next = StResp;
               w_commit     = 1'b1;
            end
         end
         StResp:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // With no wait states the commit happens on the accept edge, so use the live request.
   always_comb begin
      if (r_state == StIdle) begin
         w_we    = bus.we;
         w_size  = bus.size;
         w_uns   = bus.uns;
         w_addr  = bus.addr;
         w_wdata = bus.wdata;
      end else begin
         w_we    = r_we;
         w_size  = r_size;
         w_uns   = r_uns;
         w_addr  = r_addr;
         w_wdata = r_wdata;
      end
   end

   assign w_idx = w_addr[AW+1:2];
   assign w_oob = |w_addr[31:AW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = ((w_size == 2'b01) && w_addr[0]) || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
`else
   assign w_mis = 1'b0;
`endif
   assign w_err = w_oob || (w_size == 2'b11) || w_mis;

   assign w_bsh  = {w_addr[1:0], 3'b000};
   assign w_hsh  = {w_addr[1], 4'b0000};
   assign w_old  = r_mem[w_idx];
   assign w_byte = 8'(w_old >> w_bsh);
   assign w_half = 16'(w_old >> w_hsh);

   always_comb begin
      w_mask = 32'h0;
      w_wdat = 32'h0;
      w_load = 32'h0;
      unique case (w_size)
         2'b00: begin
            w_mask = 32'h0000_00FF << w_bsh;
            w_wdat = {24'h0, w_wdata[7:0]} << w_bsh;
            w_load = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         2'b01: begin
            w_mask = 32'h0000_FFFF << w_hsh;
            w_wdat = {16'h0, w_wdata[15:0]} << w_hsh;
            w_load = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         2'b10: begin
            w_mask = 32'hFFFF_FFFF;
            w_wdat = w_wdata;
            w_load = w_old;
         end
         default: ;
      endcase
   end

   assign w_new = (w_old & ~w_mask) | (w_wdat & w_mask);

   always_ff @(posedge clk) begin
      if (w_commit && w_we && !w_err) begin
         r_mem[w_idx] <= w_new;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_done  <= 1'b0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_commit;
         if (w_accept) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_uns   <= bus.uns;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= CNT_INIT;
         end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= w_err ? 32'h0 : w_load;
         end
      end
   end

   assign bus.ready = (r_state == StIdle);
   assign bus.done  = r_done;
   assign bus.rdata = r_rdata;
   assign bus.err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table through a scoreboard on a WAIT_CYCLES=1
// instance, plus hand sequences for held req, reset during WAIT and a zero-wait instance.
module tb_dmem_ctrl;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        chk_rd;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
      logic        chk_rd;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   acc_cnt = 0;
   exp_t q[$];
   vec_t vecs[$];

   dmem_ctrl_if b1 ();
   dmem_ctrl_if b0 ();

   dmem_ctrl #(.DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
   dmem_ctrl #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (b1.req && b1.ready) begin
         acc_cnt <= acc_cnt + 1;
         acc_cyc <= cyc;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard consumer: every done on the W=1 instance must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && b1.done) begin
         if (q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk($sformatf("vec%0d_err", e.id), 32'(b1.err), 32'(e.err));
            if (e.chk_rd) chk($sformatf("vec%0d_rdata", e.id), b1.rdata, e.rdata);
            chk($sformatf("vec%0d_latency", e.id), 32'(cyc - acc_cyc), 32'd2);
         end
      end
   end

   function automatic vec_t v(input logic we, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic er, input logic cr);
      vec_t r;
      r.we = we; r.size = sz; r.uns = u; r.addr = a; r.wdata = wd;
      r.rdata = rd; r.err = er; r.chk_rd = cr;
      return r;
   endfunction

   task automatic drive1(input vec_t t);
      b1.req = 1'b1; b1.we = t.we; b1.size = t.size; b1.uns = t.uns;
      b1.addr = t.addr; b1.wdata = t.wdata;
   endtask

   task automatic run_txn(input vec_t t, input int id);
      int n;
      @(negedge clk);
      drive1(t);
      q.push_back('{id, t.rdata, t.err, t.chk_rd});
      n = 0;
      while (!b1.ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      b1.req = 1'b0;
      n = 0;
      while (!b1.done && n < 20) begin @(negedge clk); n++; end
      if (!b1.done) chk($sformatf("vec%0d_done_timeout", id), 32'd0, 32'd1);
   endtask

   task automatic run0(input string nm, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic er, input logic cr);
      @(negedge clk);
      chk({nm, "_ready"}, 32'(b0.ready), 32'd1);
      b0.req = 1'b1; b0.we = we; b0.size = sz; b0.uns = u; b0.addr = a; b0.wdata = wd;
      @(negedge clk);
      b0.req = 1'b0;
      chk({nm, "_done"}, 32'(b0.done), 32'd1);
      chk({nm, "_err"}, 32'(b0.err), 32'(er));
      if (cr) chk({nm, "_rdata"}, b0.rdata, rd);
      @(negedge clk);
      chk({nm, "_done_drop"}, 32'(b0.done), 32'd0);
   endtask

   initial begin
      int n, low, acc0;
      b1.req = 0; b1.we = 0; b1.size = 0; b1.uns = 0; b1.addr = 0; b1.wdata = 0;
      b0.req = 0; b0.we = 0; b0.size = 0; b0.uns = 0; b0.addr = 0; b0.wdata = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(b1.ready), 32'd1);
      chk("rst_done", 32'(b1.done), 32'd0);
      chk("rst_rdata", b1.rdata, 32'd0);
      chk("rst_err", 32'(b1.err), 32'd0);

      vecs.push_back(v(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0));
      vecs.push_back(v(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1));
      vecs.push_back(v(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 0));
      vecs.push_back(v(1, 2'b00, 0, 32'h21, 32'h123456AA, 0, 0, 0));
      vecs.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h1122AA44, 0, 1));
      vecs.push_back(v(0, 2'b00, 0, 32'h21, 0, 32'hFFFFFFAA, 0, 1));
      vecs.push_back(v(0, 2'b00, 1, 32'h21, 0, 32'h000000AA, 0, 1));
      vecs.push_back(v(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 0));
      vecs.push_back(v(1, 2'b01, 0, 32'h22, 32'hABCD8001, 0, 0, 0));
      vecs.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h80013344, 0, 1));
      vecs.push_back(v(0, 2'b01, 0, 32'h22, 0, 32'hFFFF8001, 0, 1));
      vecs.push_back(v(0, 2'b01, 1, 32'h22, 0, 32'h00008001, 0, 1));
      vecs.push_back(v(1, 2'b10, 0, 32'h00, 32'h01020304, 0, 0, 0));
      vecs.push_back(v(1, 2'b10, 0, 32'h100, 32'hFFFFFFFF, 0, 1, 0));
      vecs.push_back(v(0, 2'b10, 0, 32'h00, 0, 32'h01020304, 0, 1));
      vecs.push_back(v(0, 2'b11, 0, 32'h00, 0, 32'h0, 1, 1));
      vecs.push_back(v(0, 2'b00, 0, 32'h23, 0, 32'hFFFFFF80, 0, 1));
      vecs.push_back(v(0, 2'b01, 1, 32'h20, 0, 32'h00003344, 0, 1));
      vecs.push_back(v(1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 0, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
      vecs.push_back(v(0, 2'b10, 0, 32'h02, 0, 32'h0, 1, 1));
`else
      vecs.push_back(v(0, 2'b10, 0, 32'h02, 0, 32'h01020304, 0, 1));
`endif
      foreach (vecs[i]) run_txn(vecs[i], i);

      // req held high for the whole transaction: one accept, ready low for two cycles.
      @(negedge clk);
      acc0 = acc_cnt;
      drive1(v(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1));
      q.push_back('{100, 32'hDEADBEEF, 1'b0, 1'b1});
      low = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!b1.ready) low++;
      end while (!b1.done && n < 20);
      b1.req = 1'b0;
      @(negedge clk);
      chk("hold_accepts", 32'(acc_cnt - acc0), 32'd1);
      chk("hold_ready_low", 32'(low), 32'd2);
      chk("hold_rdata_kept", b1.rdata, 32'hDEADBEEF);

      // Reset pulse while the store sits in WAIT: aborted, no done, no write.
      @(negedge clk);
      drive1(v(1, 2'b10, 0, 32'h08, 32'h5, 0, 0, 0));
      @(posedge clk); #1;
      b1.req = 1'b0;
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      n = 0;
      repeat (4) begin
         @(negedge clk);
         if (b1.done) n++;
      end
      chk("abort_no_done", 32'(n), 32'd0);
      chk("abort_ready", 32'(b1.ready), 32'd1);
      run_txn(v(0, 2'b10, 0, 32'h08, 0, 32'hCAFEF00D, 0, 1), 101);

      run0("w0_sw", 1, 2'b10, 0, 32'h04, 32'h00000077, 0, 0, 0);
      run0("w0_lb", 0, 2'b00, 0, 32'h04, 0, 32'h00000077, 0, 1);
      run0("w0_sh", 1, 2'b01, 0, 32'h06, 32'h0000FFFE, 0, 0, 0);
      run0("w0_lw", 0, 2'b10, 0, 32'h04, 0, 32'hFFFE0077, 0, 1);
      run0("w0_oob", 1, 2'b10, 0, 32'h40, 32'h12345678, 0, 1, 0);
      run0("w0_lw2", 0, 2'b10, 0, 32'h04, 0, 32'hFFFE0077, 0, 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
